// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and pointer helper for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Cyclic increment with an explicit compare so non-power-of-two N wraps correctly
  function automatic int ptr_inc(input int p, input int n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signal bundle
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_last;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wfull;
  logic                        fifo_winc;
  logic [DATA_WIDTH-1:0]       fifo_wdata;

  // Requesters plus the FIFO full flag: the environment around the arbiter
  modport master (
    output req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_winc, fifo_wdata
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_winc, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - rotating-priority encoder, first valid at or after base
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    base,
  output logic [PW-1:0]    winner,
  output logic             any_valid
);

  int            idx_int;
  logic [PW-1:0] idx;

  // Scan N_REQ positions starting at base, wrapping by subtraction; first hit wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx_int   = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_int = int'(base) + k;
      if (idx_int >= N_REQ) idx_int = idx_int - N_REQ;
      idx = PW'(idx_int);
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write-port arbiter; burst locking under FIFO_WR_ARB_BURST_EN
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_MAX  = 16
) (
  input  logic                     wclk,
  input  logic                     reset,
  fifo_wr_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     burst_err
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] pick;
  logic          any_valid;
  logic [PW-1:0] sel;
  logic          eligible;
  logic          xfer;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req       (bus.req_valid),
    .base      (rr_ptr),
    .winner    (pick),
    .any_valid (any_valid)
  );

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_t    state, state_nx;
  logic [PW-1:0] owner, owner_nx, rr_nx, grant_nx;
  logic [BW-1:0] beat_cnt, beat_nx, beat_inc;
  logic          err_nx;

  assign busy     = (state == ARB_LOCK);
  assign beat_inc = beat_cnt + BW'(1);

  // Select the candidate: the lock owner during a burst, else the rotating pick
  always_comb begin
    sel      = pick;
    eligible = any_valid;
    if (state == ARB_LOCK) begin
      sel      = owner;
      eligible = 1'b1;
    end
  end

  // Next state: open a lock on a non-last word, close it on last or beat limit
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    beat_nx  = beat_cnt;
    err_nx   = burst_err;
    grant_nx = grant_id;
    if (xfer) begin
      grant_nx = sel;
      if (state == ARB_IDLE) begin
        if (bus.req_last[sel]) begin
          rr_nx = PW'(ptr_inc(int'(sel), N_REQ));
        end else begin
          state_nx = ARB_LOCK;
          owner_nx = sel;
          beat_nx  = BW'(1);
        end
      end else begin
        beat_nx = beat_inc;
        if (bus.req_last[sel] || (beat_inc == BW'(BURST_MAX))) begin
          state_nx = ARB_IDLE;
          rr_nx    = PW'(ptr_inc(int'(owner), N_REQ));
          beat_nx  = '0;
          if (!bus.req_last[sel]) err_nx = 1'b1;
        end
      end
    end
  end

  // State and pointer registers; reset abandons any lock
  always_ff @(posedge wclk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_nx;
      rr_ptr    <= rr_nx;
      owner     <= owner_nx;
      beat_cnt  <= beat_nx;
      burst_err <= err_nx;
      grant_id  <= grant_nx;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^bus.req_last;
  assign busy        = 1'b0;
  assign burst_err   = 1'b0;

  // Every word is its own burst, so the rotating pick is always the candidate
  always_comb begin
    sel      = pick;
    eligible = any_valid;
  end

  // Advance the pointer past the winner after each transfer
  always_ff @(posedge wclk) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant_id <= '0;
    end else if (xfer) begin
      rr_ptr   <= PW'(ptr_inc(int'(sel), N_REQ));
      grant_id <= sel;
    end
  end
`endif

  // Zero-cycle accept: ready, strobe and data follow the candidate combinationally
  always_comb begin
    xfer           = eligible & bus.req_valid[sel] & ~bus.fifo_wfull & ~reset;
    bus.req_ready  = '0;
    if (eligible && !bus.fifo_wfull && !reset) bus.req_ready[sel] = 1'b1;
    bus.fifo_winc  = xfer;
    bus.fifo_wdata = bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized directed bench with a behavioural arbiter model
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int BM = 16;

  logic         wclk = 1'b0;
  logic         reset;
  logic [1:0]   grant_id;
  logic         busy;
  logic         burst_err;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .wclk      (wclk),
    .reset     (reset),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .burst_err (burst_err)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // reference model: arbitration state expressed as plain integers
  int m_rr = 0, m_owner = 0, m_beats = 0, m_grant = 0;
  bit m_lock = 0, m_err = 0, known = 0;
  int cur_w;
  bit cur_x;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [N-1:0] v, input logic [N-1:0] l,
                     input logic f, input logic r);
    bit has;
    int w;
    logic [N-1:0] exp_t;
    bus.req_valid  = v;
    bus.req_last   = l;
    bus.fifo_wfull = f;
    reset          = r;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = {$urandom, $urandom};
    @(negedge wclk);
    has = 0;
    w   = 0;
    if (m_lock) begin
      w   = m_owner;
      has = v[w];
    end else begin
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (!has && v[i]) begin has = 1; w = i; end
      end
    end
    cur_x = has && !f && !r;
    cur_w = w;
    exp_t = cur_x ? (N'(1) << w) : '0;
    chk({tag, ".winc"}, 64'(bus.fifo_winc), 64'(cur_x));
    chk({tag, ".xfer"}, 64'(bus.req_ready & v), 64'(exp_t));
    if (cur_x) chk({tag, ".wdata"}, bus.fifo_wdata, bus.req_data[w*DW +: DW]);
    if (known) begin
      chk({tag, ".grant"}, 64'(grant_id), 64'(m_grant));
      chk({tag, ".busy"}, 64'(busy), 64'(m_lock));
      chk({tag, ".err"}, 64'(burst_err), 64'(m_err));
    end
    @(posedge wclk);
    if (r) begin
      m_rr = 0; m_owner = 0; m_beats = 0; m_grant = 0; m_lock = 0; m_err = 0;
      known = 1;
    end else if (cur_x) begin
      m_grant = w;
`ifdef FIFO_WR_ARB_BURST_EN
      if (!m_lock) begin
        if (l[w]) m_rr = (w + 1) % N;
        else begin m_lock = 1; m_owner = w; m_beats = 1; end
      end else begin
        m_beats++;
        if (l[w] || m_beats == BM) begin
          if (!l[w]) m_err = 1;
          m_lock = 0;
          m_rr   = (m_owner + 1) % N;
        end
      end
`else
      m_rr = (w + 1) % N;
`endif
    end
    #1;
  endtask

  initial begin
    // reset with all requesters valid: nothing may be accepted
    cyc("rst0", 4'b1111, 4'b1111, 1'b0, 1'b1);
    cyc("rst1", 4'b1111, 4'b1111, 1'b0, 1'b1);
    // single-beat round robin 0,1,2,3,0
    for (int i = 0; i < 5; i++) cyc("rr", 4'b1111, 4'b1111, 1'b0, 1'b0);
    chk("rr.final_grant", 64'(grant_id), 64'd0);
    // req1 three-word burst with req0/req2 competing
    cyc("b3a", 4'b0111, 4'b1101, 1'b0, 1'b0);
    cyc("b3b", 4'b0111, 4'b1101, 1'b0, 1'b0);
    cyc("b3c", 4'b0111, 4'b1111, 1'b0, 1'b0);
    cyc("b3n", 4'b0111, 4'b1111, 1'b0, 1'b0);
    // burst stalled by a full FIFO for five cycles, others valid meanwhile
    cyc("wfa", 4'b1000, 4'b0000, 1'b0, 1'b0);
    cyc("wfb", 4'b1000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("wful", 4'b1011, 4'b0000, 1'b1, 1'b0);
    cyc("wfc", 4'b1011, 4'b0000, 1'b0, 1'b0);
    cyc("wfd", 4'b1011, 4'b1111, 1'b0, 1'b0);
    // req3 streams BURST_MAX words without last
    for (int i = 0; i < BM + 2; i++) cyc("bmax", 4'b1000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("post", 4'b1001, 4'b1111, 1'b0, 1'b0);
    // reset during a lock at beat 4
    cyc("pre", 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("lk4", 4'b0100, 4'b0000, 1'b0, 1'b0);
    cyc("mrst", 4'b0100, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc("arst", 4'b1111, 4'b1111, 1'b0, 1'b0);
    // req2 holds last=0 while req0 valid
    cyc("alt_rst", 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("alt", 4'b0101, 4'b0000, 1'b0, 1'b0);
    // randomized traffic with occasional full and reset
    for (int i = 0; i < 400; i++)
      cyc("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
